// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and default sizing for the PWM duty scheduler
package pwm_pkg;

    localparam int DEF_DUTY_W = 10;
    localparam int DEF_STEP   = 8;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RAMP = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/duty_slew.sv
// rtl/duty_slew.sv - combinational slew limiter: moves cur toward tgt by at most STEP
module duty_slew
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DEF_DUTY_W,
    parameter int STEP   = DEF_STEP
) (
    input  logic [DUTY_W-1:0] cur,
    input  logic [DUTY_W-1:0] tgt,
    output logic [DUTY_W-1:0] next
);

    localparam logic [DUTY_W:0] STEP_X = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W:0] MAX_X  = {1'b0, {DUTY_W{1'b1}}};

    logic [DUTY_W:0] cur_x;
    logic [DUTY_W:0] tgt_x;
    logic [DUTY_W:0] diff;
    logic [DUTY_W:0] up;
    logic [DUTY_W:0] dn;
    logic            rising;

    // One guard bit: up saturates at full scale, dn's sign bit flags a would-be wrap below zero.
    always_comb begin
        cur_x  = {1'b0, cur};
        tgt_x  = {1'b0, tgt};
        rising = (tgt_x >= cur_x);
        diff   = rising ? (tgt_x - cur_x) : (cur_x - tgt_x);
        up     = cur_x + STEP_X;
        dn     = cur_x - STEP_X;
        next   = tgt;
        if (diff > STEP_X) begin
            if (rising) begin
                next = (up > MAX_X) ? MAX_X[DUTY_W-1:0] : up[DUTY_W-1:0];
            end else begin
                next = dn[DUTY_W] ? '0 : dn[DUTY_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pwm_duty_sched.sv
// rtl/pwm_duty_sched.sv - two-requester duty arbiter with per-frame slew-limited duty update
module pwm_duty_sched
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DEF_DUTY_W,
    parameter int STEP   = DEF_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req_a,
    input  logic [DUTY_W-1:0] duty_a,
    input  logic              req_b,
    input  logic [DUTY_W-1:0] duty_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DUTY_W-1:0] duty,
    output logic              frame_sync,
    output logic              busy
);

    logic [DUTY_W-1:0] frame_cnt;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] target_nxt;
    logic [DUTY_W-1:0] duty_nxt;
    logic [DUTY_W-1:0] slew_duty;
    logic              gnt_a;
    logic              gnt_b;
    logic              settled;
    pwm_state_t        state;
    pwm_state_t        state_nxt;

    assign frame_sync = (frame_cnt == {DUTY_W{1'b1}});

    assign gnt_b = en & req_b;
    assign gnt_a = en & req_a & ~req_b;

    duty_slew #(
        .DUTY_W (DUTY_W),
        .STEP   (STEP)
    ) u_slew (
        .cur  (duty),
        .tgt  (target),
        .next (slew_duty)
    );

    always_comb begin
        target_nxt = target;
        if (!en) begin
            target_nxt = '0;
        end else if (gnt_b) begin
            target_nxt = duty_b;
        end else if (gnt_a) begin
            target_nxt = duty_a;
        end
    end

    // Slew sees the registered target, so a grant on a frame edge only counts from the next frame.
    assign duty_nxt = frame_sync ? slew_duty : duty;
    assign settled  = (duty_nxt == target_nxt);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF: begin
                if (en) begin
                    state_nxt = settled ? ST_IDLE : ST_RAMP;
                end
            end
            default: begin
                if (!en && (duty == '0)) begin
                    state_nxt = ST_OFF;
                end else begin
                    state_nxt = settled ? ST_IDLE : ST_RAMP;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            duty      <= '0;
            target    <= '0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            state     <= en ? ST_IDLE : ST_OFF;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
            duty      <= duty_nxt;
            target    <= target_nxt;
            ack_a     <= gnt_a;
            ack_b     <= gnt_b;
            state     <= state_nxt;
        end
    end

    assign busy = (state == ST_RAMP);

endmodule

// File: tb/tb_pwm_duty_sched.sv
// tb/tb_pwm_duty_sched.sv - directed bench: STEP=8 scenarios plus a wide-step slew table
module tb_pwm_duty_sched;

    localparam int W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst1, en1, req_a1, req_b1, ack_a1, ack_b1, fs1, busy1;
    logic [W-1:0] duty_a1, duty_b1, duty1;
    logic         rst2, en2, req_a2, req_b2, ack_a2, ack_b2, fs2, busy2;
    logic [W-1:0] duty_a2, duty_b2, duty2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic         do_req;
        logic [W-1:0] tgt;
        logic [W-1:0] exp_duty;
        logic         exp_busy;
    } vec_t;

    vec_t vecs [13];

    pwm_duty_sched #(.DUTY_W(W), .STEP(8)) dut1 (
        .clk(clk), .rst(rst1), .en(en1),
        .req_a(req_a1), .duty_a(duty_a1), .req_b(req_b1), .duty_b(duty_b1),
        .ack_a(ack_a1), .ack_b(ack_b1), .duty(duty1), .frame_sync(fs1), .busy(busy1)
    );

    pwm_duty_sched #(.DUTY_W(W), .STEP(510)) dut2 (
        .clk(clk), .rst(rst2), .en(en2),
        .req_a(req_a2), .duty_a(duty_a2), .req_b(req_b2), .duty_b(duty_b2),
        .ack_a(ack_a2), .ack_b(ack_b2), .duty(duty2), .frame_sync(fs2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_fs1(output logic ack_seen);
        int n;
        n = 0;
        ack_seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (ack_a1 || ack_b1) ack_seen = 1'b1;
        end while (!fs1 && n < 1100);
        if (!fs1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_wait1: got no frame_sync in %0d cycles, expected one", n);
        end
        @(negedge clk);
    endtask

    task automatic wait_fs2();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs2 && n < 1100);
        if (!fs2) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_wait2: got no frame_sync in %0d cycles, expected one", n);
        end
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        // Second instance, STEP=0x1FE; rows start from duty=target=0x100.
        vecs[0]  = '{1'b1, 10'h3FC, 10'h2FE, 1'b1};
        vecs[1]  = '{1'b0, 10'h000, 10'h3FC, 1'b0};
        vecs[2]  = '{1'b1, 10'h3FF, 10'h3FF, 1'b0};
        vecs[3]  = '{1'b1, 10'h004, 10'h201, 1'b1};
        vecs[4]  = '{1'b0, 10'h000, 10'h004, 1'b0};
        vecs[5]  = '{1'b1, 10'h000, 10'h000, 1'b0};
        vecs[6]  = '{1'b1, 10'h080, 10'h080, 1'b0};
        vecs[7]  = '{1'b1, 10'h27E, 10'h27E, 1'b0};
        vecs[8]  = '{1'b1, 10'h080, 10'h080, 1'b0};
        vecs[9]  = '{1'b1, 10'h27F, 10'h27E, 1'b1};
        vecs[10] = '{1'b0, 10'h000, 10'h27F, 1'b0};
        vecs[11] = '{1'b1, 10'h080, 10'h081, 1'b1};
        vecs[12] = '{1'b0, 10'h000, 10'h080, 1'b0};

        fork
            begin : seq1
                logic seen;
                logic off_seen;
                int   n;
                int   exp_d;
                rst1 = 1'b1; en1 = 1'b1; req_a1 = 1'b0; req_b1 = 1'b0;
                duty_a1 = '0; duty_b1 = '0;
                repeat (3) @(negedge clk);
                chk("rst_duty", duty1, 0);
                chk("rst_busy", busy1, 0);
                chk("rst_acks", {ack_a1, ack_b1}, 0);
                chk("rst_frame_sync", fs1, 0);
                rst1 = 1'b0;
                n = 0;
                while (!fs1 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                chk("first_frame_sync_delay", n, 1023);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!fs1 && n < 2000);
                chk("frame_period", n, 1024);

                // Grant lands on the frame edge: duty must still slew toward the old target (0).
                req_a1 = 1'b1; duty_a1 = 10'h040;
                @(negedge clk);
                chk("ack_a_on_frame_edge", ack_a1, 1);
                chk("frame_edge_grant_old_target", duty1, 0);
                req_a1 = 1'b0;
                for (int f = 1; f <= 4; f++) begin
                    wait_fs1(seen);
                    chk($sformatf("up_to_20_f%0d", f), duty1, 8 * f);
                end

                en1 = 1'b0; req_a1 = 1'b1; duty_a1 = 10'h1FF;
                off_seen = 1'b0;
                for (int f = 1; f <= 4; f++) begin
                    wait_fs1(seen);
                    off_seen = off_seen | seen;
                    chk($sformatf("rampdown_f%0d", f), duty1, 32 - 8 * f);
                end
                chk("off_busy", busy1, 0);
                chk("no_ack_while_disabled", off_seen, 0);
                en1 = 1'b1;
                @(negedge clk);
                chk("ack_after_enable", ack_a1, 1);
                chk("busy_after_enable", busy1, 1);
                req_a1 = 1'b0;

                for (int f = 1; f <= 64; f++) begin
                    wait_fs1(seen);
                    exp_d = (8 * f > 'h1FF) ? 'h1FF : 8 * f;
                    chk($sformatf("ramp_1ff_f%0d", f), duty1, exp_d);
                    if (f == 63) chk("ramp_busy_f63", busy1, 1);
                    if (f == 64) chk("ramp_busy_f64", busy1, 0);
                end

                req_a1 = 1'b1; duty_a1 = 10'h100;
                req_b1 = 1'b1; duty_b1 = 10'h300;
                @(negedge clk);
                chk("prio_ack_b_first", ack_b1, 1);
                chk("prio_ack_a_held", ack_a1, 0);
                req_b1 = 1'b0;
                @(negedge clk);
                chk("prio_ack_a_second", ack_a1, 1);
                chk("prio_ack_b_pulse", ack_b1, 0);
                req_a1 = 1'b0;
                @(negedge clk);
                chk("prio_ack_a_pulse", ack_a1, 0);
                wait_fs1(seen);
                chk("prio_final_target_dir", duty1, 'h1F7);
                chk("prio_busy", busy1, 1);
            end

            begin : seq2
                int n;
                rst2 = 1'b1; en2 = 1'b1; req_a2 = 1'b0; req_b2 = 1'b0;
                duty_a2 = '0; duty_b2 = '0;
                repeat (3) @(negedge clk);
                rst2 = 1'b0;
                n = 0;
                while (!fs2 && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                req_a2 = 1'b1; duty_a2 = 10'h100;
                @(negedge clk);
                chk("w_ack_on_frame_edge", ack_a2, 1);
                chk("w_frame_edge_old_target", duty2, 0);
                chk("w_busy_after_grant", busy2, 1);
                req_a2 = 1'b0;
                wait_fs2();
                chk("w_new_target_next_frame", duty2, 'h100);
                chk("w_idle_after_frame", busy2, 0);

                for (int i = 0; i < 13; i++) begin
                    if (vecs[i].do_req) begin
                        req_a2 = 1'b1; duty_a2 = vecs[i].tgt;
                        @(negedge clk);
                        chk($sformatf("vec%0d_ack", i), ack_a2, 1);
                        req_a2 = 1'b0;
                    end
                    wait_fs2();
                    chk($sformatf("vec%0d_duty", i), duty2, vecs[i].exp_duty);
                    chk($sformatf("vec%0d_busy", i), busy2, vecs[i].exp_busy);
                end

                req_a2 = 1'b1; duty_a2 = 10'h300;
                @(negedge clk);
                req_a2 = 1'b0;
                chk("midramp_busy", busy2, 1);
                chk("midramp_duty", duty2, 'h080);
                rst2 = 1'b1; req_b2 = 1'b1; duty_b2 = 10'h200;
                @(negedge clk);
                chk("rst_midramp_duty", duty2, 0);
                chk("rst_midramp_acks", {ack_a2, ack_b2}, 0);
                chk("rst_midramp_busy", busy2, 0);
                rst2 = 1'b0; req_b2 = 1'b0;
                wait_fs2();
                chk("rst_drops_pending", duty2, 0);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sched.md
PWM_DUTY_SCHED -- requirements
Module: pwm_duty_sched

Interface
REQ-001 SHALL have parameter DUTY_W, default 10, the duty width matching the pwm block's duty input.
REQ-002 SHALL have parameter STEP, default 8, the maximum duty change per frame (unsigned, 1..2^DUTY_W-1).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  enable; low forces the target to 0 (controlled ramp-down).
REQ-006 SHALL have ports req_a  input  1 and duty_a  input  DUTY_W  for requester A (control loop) target duty.
REQ-007 SHALL have ports req_b  input  1 and duty_b  input  DUTY_W  for requester B (override) target duty.
REQ-008 SHALL have ports ack_a and ack_b  output  1 each  as one-cycle acceptance pulses.
REQ-009 SHALL have port duty  output  DUTY_W  registered duty that drives the pwm duty input.
REQ-010 SHALL have port frame_sync  output  1  one-cycle pulse on the last cycle of each 2^DUTY_W-cycle frame.
REQ-011 SHALL have port busy  output  1  high while duty != target.

Function
REQ-012 SHALL run a free-running DUTY_W-bit frame counter that wraps from 2^DUTY_W-1 to 0, with frame_sync=1 exactly when the count is 2^DUTY_W-1.
REQ-013 SHALL grant at most one request per cycle, with B having fixed priority over A.
REQ-014 SHALL, on a grant, load target from the granted duty_x on the next edge and pulse that requester's ack for exactly one cycle.
REQ-015 SHALL keep an ungranted request pending and not acknowledge it; the requester holds req and data until ack.
REQ-016 SHALL require requesters to drop req in the cycle after ack; a held req is treated as a new request.
REQ-017 SHALL accept no requests while en=0, hold both acks low, and force target to 0.
REQ-018 SHALL change duty only on the edge at which frame_sync=1, so duty is constant within a frame.
REQ-019 SHALL use the slew rule at a frame edge: if |target-duty| <= STEP then duty=target, else duty moves STEP toward target.
REQ-020 SHALL compute the slew in DUTY_W+1 bits so duty never wraps or overflows and is clamped within 0..2^DUTY_W-1.
REQ-021 SHALL implement FSM states IDLE (duty==target), RAMP (duty!=target) and OFF (en=0 and duty==0).
REQ-022 SHALL take these transitions: IDLE->RAMP when a grant changes target; RAMP->IDLE when duty reaches target on a frame edge; any->OFF when en=0 and duty==0; OFF->IDLE when en=1.
REQ-023 SHALL, when a new target is accepted mid-ramp, continue the ramp from the current duty toward the new target without skipping a frame.
REQ-024 SHALL, when a grant and a frame edge fall in the same cycle, slew using the old target, with the new target taking effect on the next frame.
REQ-025 SHALL drive busy = (state==RAMP).

Reset
REQ-026 SHALL, while rst=1 at an edge, set duty=0, target=0, frame counter=0, state=OFF if en=0 else IDLE, and ack_a=ack_b=0.
REQ-027 SHALL treat a reset mid-ramp as aborting the ramp: duty goes to 0 immediately, pending requests are dropped, and requesters re-assert.

Structure
REQ-028 SHALL place the FSM state enum and default DUTY_W/STEP constants in the shared package pwm_pkg.
REQ-029 SHALL be a single module; the frame counter stays inline, and the slew limiter may be a sub-module named duty_slew (combinational: cur, tgt -> next).

Verification
REQ-030 SHALL cover: rst pulse then en=1 -> duty=0, busy=0, first frame_sync 1023 cycles after reset release, then every 1024 cycles.
REQ-031 SHALL cover: req_a with duty_a=0x1FF -> ack_a next cycle; duty steps by 8 per frame, reaches 0x1F8 after 63 frames and 0x1FF after 64 frames; busy then falls.
REQ-032 SHALL cover: req_a=0x100 and req_b=0x300 in the same cycle -> ack_b first, ack_a one cycle later; final target 0x100.
REQ-033 SHALL cover: duty=0x3FC with target 0x3FF -> next frame duty=0x3FF (no overflow); duty=0x004 with target 0 -> next frame duty=0 (no wrap).
REQ-034 SHALL cover: en dropped at duty=0x020 -> duty 0x018, 0x010, 0x008, 0x000 on four frames; state OFF; a req_a asserted during ramp-down is not acked until en=1.
REQ-035 SHALL cover: rst asserted mid-ramp at duty=0x080 -> duty=0 on the next edge and ack_a/ack_b=0.
